// File: rtl/truth_table_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_scanner
//  Description : Walks every input combination of an external N_IN-input,
//                single-output function in ascending order. Each row is held
//                for SETTLE+1 cycles before the function output is sampled.
//                The captured truth table is compared with a latched expected
//                vector, and the block reports pass/fail, the mismatch count
//                and the first mismatching row.
//  Revision    : 1.0  initial release
// ============================================================================
module truth_table_scanner #(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [(1<<N_IN)-1:0]   expected,
   output logic [N_IN-1:0]        dut_in,
   input  logic                   dut_out,
   output logic                   busy,
   output logic                   done,
   output logic [(1<<N_IN)-1:0]   table_out,
   output logic                   pass,
   output logic [N_IN:0]          mismatch_cnt,
   output logic [N_IN-1:0]        mismatch_idx
);

   localparam int              ROWS     = 1 << N_IN;
   localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
   localparam logic [N_IN-1:0] LAST_ROW = N_IN'(ROWS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [N_IN-1:0]   idx;
   logic [3:0]        cnt;
   logic [ROWS-1:0]   exp_q;

   logic              row_miss;
   logic [N_IN:0]     cnt_next;

   // Mismatch for the row currently being sampled, and the running count including it
   assign row_miss = (dut_out != exp_q[idx]);
   assign cnt_next = mismatch_cnt + (N_IN+1)'(row_miss);

   // Scan controller: accept a request, step through the rows, report results
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= '0;
         cnt          <= '0;
         exp_q        <= '0;
         dut_in       <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         table_out    <= '0;
         pass         <= 1'b0;
         mismatch_cnt <= '0;
         mismatch_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  exp_q        <= expected;
                  table_out    <= '0;
                  mismatch_cnt <= '0;
                  mismatch_idx <= '0;
                  pass         <= 1'b0;
                  idx          <= '0;
                  cnt          <= '0;
                  dut_in       <= '0;
                  busy         <= 1'b1;
                  state        <= SCAN;
               end
            end

            SCAN: begin
               if (cnt < SETTLE_C) begin
                  cnt <= cnt + 4'd1;
               end else begin
                  table_out[idx] <= dut_out;
                  mismatch_cnt   <= cnt_next;
                  // Only the first differing row is recorded
                  if (row_miss && (mismatch_cnt == '0)) begin
                     mismatch_idx <= idx;
                  end
                  cnt <= '0;
                  if (idx == LAST_ROW) begin
                     // dut_in intentionally keeps the last row value
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (cnt_next == '0);
                  end else begin
                     idx    <= idx + N_IN'(1);
                     dut_in <= idx + N_IN'(1);
                  end
               end
            end

            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_truth_table_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_truth_table_scanner
//  Description : Self-checking bench for truth_table_scanner. Instance 0 runs
//                N_IN=2/SETTLE=1 against f=x (or f=y), instance 1 runs
//                N_IN=2/SETTLE=3 against f=x^y.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_truth_table_scanner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       fsel;
   logic       start_s    [2];
   logic [3:0] exp_s      [2];
   logic [1:0] dut_in_s   [2];
   logic       dut_out_s  [2];
   logic       busy_s     [2];
   logic       done_s     [2];
   logic [3:0] table_s    [2];
   logic       pass_s     [2];
   logic [2:0] mcnt_s     [2];
   logic [1:0] midx_s     [2];

   int errors = 0;
   int checks = 0;
   int seqbuf [0:63];

   always #5 clk = ~clk;

   // Functions under test (x = dut_in[1], y = dut_in[0])
   assign dut_out_s[0] = fsel ? dut_in_s[0][0]
                              : (~(~dut_in_s[0][1] & dut_in_s[0][0]) & ~(~dut_in_s[0][1] & ~dut_in_s[0][0]));
   assign dut_out_s[1] = dut_in_s[1][1] ^ dut_in_s[1][0];

   truth_table_scanner #(.N_IN(2), .SETTLE(1)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .expected(exp_s[0]),
      .dut_in(dut_in_s[0]), .dut_out(dut_out_s[0]), .busy(busy_s[0]), .done(done_s[0]),
      .table_out(table_s[0]), .pass(pass_s[0]), .mismatch_cnt(mcnt_s[0]), .mismatch_idx(midx_s[0])
   );

   truth_table_scanner #(.N_IN(2), .SETTLE(3)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .expected(exp_s[1]),
      .dut_in(dut_in_s[1]), .dut_out(dut_out_s[1]), .busy(busy_s[1]), .done(done_s[1]),
      .table_out(table_s[1]), .pass(pass_s[1]), .mismatch_cnt(mcnt_s[1]), .mismatch_idx(midx_s[1])
   );

   task automatic chk(input string name, input int inst, input logic [7:0] act, input logic [7:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s[%0d]: got %0h, want %0h at %0t", name, inst, act, want, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit         m_valid = 1'b0;
   int         m_t   [2];
   int         m_ph  [2];   // 0 idle, 1 scanning, 2 reporting
   logic [3:0] m_exp [2];
   logic [1:0] m_din [2];
   logic       m_busy[2];
   logic       m_done[2];
   logic       m_pass[2];
   logic [3:0] m_tbl [2];
   logic [2:0] m_cnt [2];
   logic [1:0] m_idx [2];

   function automatic int settle_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic logic [3:0] truth(input int i);
      logic [3:0] r;
      logic [1:0] kk;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         kk = 2'(k);
         if (i == 1) r[k] = kk[1] ^ kk[0];
         else        r[k] = fsel ? kk[0] : kk[1];
      end
      return r;
   endfunction

   // Results after the first n rows have been sampled
   task automatic set_partial(input int i, input int n);
      logic [3:0] mask;
      logic [3:0] diff;
      mask     = 4'((1 << n) - 1);
      diff     = (truth(i) ^ m_exp[i]) & mask;
      m_tbl[i] = truth(i) & mask;
      m_cnt[i] = 3'($countones(diff));
      m_idx[i] = 2'd0;
      for (int k = 3; k >= 0; k--) if (diff[k]) m_idx[i] = 2'(k);
   endtask

   task automatic model_step(input int i);
      int n;
      if (!rst_n) begin
         m_valid = 1'b1;
         m_ph[i] = 0;  m_t[i] = 0;  m_exp[i] = '0; m_din[i] = '0;
         m_busy[i] = 0; m_done[i] = 0; m_pass[i] = 0;
         m_tbl[i] = '0; m_cnt[i] = '0; m_idx[i] = '0;
      end else begin
         case (m_ph[i])
            0: begin
               m_done[i] = 1'b0;
               if (start_s[i]) begin
                  m_exp[i] = exp_s[i]; m_t[i] = 0; m_ph[i] = 1;
                  m_busy[i] = 1'b1; m_din[i] = '0; m_pass[i] = 1'b0;
                  m_tbl[i] = '0; m_cnt[i] = '0; m_idx[i] = '0;
               end
            end
            1: begin
               m_t[i]++;
               n = m_t[i] / (settle_of(i) + 1);
               set_partial(i, (n > 4) ? 4 : n);
               if (n >= 4) begin
                  m_busy[i] = 1'b0; m_done[i] = 1'b1;
                  m_pass[i] = (m_cnt[i] == 3'd0);
                  m_ph[i]   = 2;
               end else begin
                  m_din[i] = 2'(n);
               end
            end
            default: begin
               m_done[i] = 1'b0;
               m_ph[i]   = 0;
            end
         endcase
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         for (int i = 0; i < 2; i++) model_step(i);
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
               chk("dut_in",       i, 8'(dut_in_s[i]), 8'(m_din[i]));
               chk("busy",         i, 8'(busy_s[i]),   8'(m_busy[i]));
               chk("done",         i, 8'(done_s[i]),   8'(m_done[i]));
               chk("table_out",    i, 8'(table_s[i]),  8'(m_tbl[i]));
               chk("pass",         i, 8'(pass_s[i]),   8'(m_pass[i]));
               chk("mismatch_cnt", i, 8'(mcnt_s[i]),   8'(m_cnt[i]));
               chk("mismatch_idx", i, 8'(midx_s[i]),   8'(m_idx[i]));
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic run_scan(input int i, input logic [3:0] e, input bit hold, input int len,
                           output int first_dn, output int ndone);
      first_dn = 0;
      ndone    = 0;
      @(negedge clk);
      exp_s[i]   = e;
      start_s[i] = 1'b1;
      for (int n = 1; n <= len; n++) begin
         @(negedge clk);
         if (!hold || n == len) start_s[i] = 1'b0;
         seqbuf[n] = int'(dut_in_s[i]);
         if (done_s[i]) begin
            ndone++;
            if (first_dn == 0) first_dn = n;
         end
      end
      if (first_dn == 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout[%0d]: got no done pulse within %0d cycles", i, len);
      end
   endtask

   task automatic chk_result(input int i, input logic [3:0] tbl, input logic p,
                             input logic [2:0] c, input logic [1:0] x);
      chk("lit_table", i, 8'(table_s[i]), 8'(tbl));
      chk("lit_pass",  i, 8'(pass_s[i]),  8'(p));
      chk("lit_cnt",   i, 8'(mcnt_s[i]),  8'(c));
      chk("lit_idx",   i, 8'(midx_s[i]),  8'(x));
   endtask

   task automatic chk_all_zero(input int i);
      chk("rst_dut_in", i, 8'(dut_in_s[i]), 8'd0);
      chk("rst_busy",   i, 8'(busy_s[i]),   8'd0);
      chk("rst_done",   i, 8'(done_s[i]),   8'd0);
      chk_result(i, 4'b0000, 1'b0, 3'd0, 2'd0);
   endtask

   initial begin
      int dn;
      int nd;
      int seen;
      rst_n      = 1'b0;
      fsel       = 1'b0;
      start_s[0] = 1'b1; start_s[1] = 1'b1;
      exp_s[0]   = 4'hF; exp_s[1]   = 4'hF;

      // Reset held for two edges with start asserted
      @(negedge clk);
      @(negedge clk);
      chk_all_zero(0);
      chk_all_zero(1);
      rst_n      = 1'b1;
      start_s[0] = 1'b0; start_s[1] = 1'b0;

      // f = x, expected matches
      run_scan(0, 4'b1100, 1'b0, 12, dn, nd);
      chk("done_cycle", 0, 8'(dn), 8'd9);
      chk("done_count", 0, 8'(nd), 8'd1);
      for (int n = 1; n <= 8; n++) chk("dut_in_seq", 0, 8'(seqbuf[n]), 8'((n - 1) / 2));
      chk_result(0, 4'b1100, 1'b1, 3'd0, 2'd0);

      // Single mismatch at row 1
      run_scan(0, 4'b1110, 1'b0, 12, dn, nd);
      chk_result(0, 4'b1100, 1'b0, 3'd1, 2'd1);

      // Every row mismatches
      run_scan(0, 4'b0011, 1'b0, 12, dn, nd);
      chk_result(0, 4'b1100, 1'b0, 3'd4, 2'd0);

      // f = y against all-zero: rows 1 and 3 differ, first stays 1
      fsel = 1'b1;
      run_scan(0, 4'b0000, 1'b0, 12, dn, nd);
      chk_result(0, 4'b1010, 1'b0, 3'd2, 2'd1);
      fsel = 1'b0;

      // start held high: back-to-back scans, one done per scan
      run_scan(0, 4'b1100, 1'b1, 20, dn, nd);
      chk("hold_done_cycle", 0, 8'(dn), 8'd9);
      chk("hold_done_count", 0, 8'(nd), 8'd2);
      chk("hold_row_timing", 0, 8'(seqbuf[7]), 8'd3);
      repeat (4) @(negedge clk);
      chk_result(0, 4'b1100, 1'b1, 3'd0, 2'd0);

      // Reset for one edge at E0+5 aborts the scan
      exp_s[0]   = 4'b1100;
      start_s[0] = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         start_s[0] = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_all_zero(0);
      seen = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (done_s[0]) seen++;
      end
      chk("abort_no_done", 0, 8'(seen), 8'd0);
      run_scan(0, 4'b1100, 1'b0, 12, dn, nd);
      chk("post_rst_done_cycle", 0, 8'(dn), 8'd9);
      chk_result(0, 4'b1100, 1'b1, 3'd0, 2'd0);

      // SETTLE=3, f = x^y
      run_scan(1, 4'b0110, 1'b0, 20, dn, nd);
      chk("s3_done_cycle", 1, 8'(dn), 8'd17);
      chk("s3_done_count", 1, 8'(nd), 8'd1);
      chk("s3_row_hold", 1, 8'(seqbuf[4]), 8'd0);
      chk("s3_row_next", 1, 8'(seqbuf[5]), 8'd1);
      chk_result(1, 4'b0110, 1'b1, 3'd0, 2'd0);

      run_scan(1, 4'b0111, 1'b0, 20, dn, nd);
      chk_result(1, 4'b0110, 1'b0, 3'd1, 2'd0);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential truth-table reader for small combinational logic under test. On a start request it drives every input combination of an external N-input, 1-output function in ascending binary order. After a programmable settle time it samples the function output and assembles the full truth-table vector. It then compares that vector against an expected vector and reports pass/fail, mismatch count and first mismatching row. It sits beside the logic-exercise blocks as the self-checking counterpart to the display-style truth-table benches.

## Interface
Parameters:
- N_IN, default 2: number of function inputs, legal range 1..4.
- SETTLE, default 1: extra cycles each combination is held before sampling, legal range 0..15.

Ports (rows = 2^N_IN):
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  scan request; sampled only in IDLE.
- expected  in  rows  expected truth table; bit k is the output for input combination k. Latched on start accept.
- dut_in  out  N_IN  combination driven to the function under test; dut_in[N_IN-1] is the MSB (x), dut_in[0] is the LSB (y).
- dut_out  in  1  function output.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when results become valid.
- table_out  out  rows  captured truth table.
- pass  out  1  high when table_out equals the latched expected vector; valid from done onward.
- mismatch_cnt  out  N_IN+1  number of rows that differ from expected.
- mismatch_idx  out  N_IN  index of the first differing row; 0 when mismatch_cnt is 0.

## Operation
- States: IDLE, SCAN, DONE.
- Reset (rst_n low at an edge):
  - State goes to IDLE.
  - All outputs go to 0: dut_in, busy, done, table_out, pass, mismatch_cnt, mismatch_idx.
  - Internal idx, cnt and latched expected are cleared.
- IDLE:
  - On start=1, the block latches expected, clears table_out, mismatch_cnt, mismatch_idx and pass, and sets idx=0, cnt=0.
  - It moves to SCAN with busy=1.
  - Otherwise the state and all results hold.
- SCAN: dut_in = idx (registered). At each edge:
  - If cnt < SETTLE: cnt++.
  - If cnt == SETTLE:
    - Capture table_out[idx] = dut_out.
    - If dut_out != expected[idx], increment mismatch_cnt; if this is the first mismatch, set mismatch_idx = idx.
    - Set cnt = 0.
    - If idx == rows-1, go to DONE; otherwise idx++.
- DONE:
  - Lasts one cycle: done=1, busy=0, pass = (mismatch_cnt == 0).
  - The next edge goes to IDLE unconditionally.
- After DONE, results hold in IDLE until the next accepted start.
- dut_in holds its last value (rows-1) after the scan until the next start or reset.
- start is ignored in SCAN and DONE. No queuing: a start held high through DONE is accepted on the first IDLE cycle.
- Arithmetic and widths:
  - idx and dut_in are N_IN bits; idx never wraps because the scan exits at rows-1.
  - cnt is 4 bits.
  - mismatch_cnt is N_IN+1 bits, so it reaches rows without overflow.
- rst_n low during SCAN or DONE aborts the scan: the partial table is discarded and no done pulse is produced.

## Timing
- Start accept edge = E0. busy and dut_in=0 are visible in the cycle after E0.
- Each row occupies SETTLE+1 cycles.
- Row k is sampled at edge E0 + (k+1)(SETTLE+1).
- The last sample edge is E0 + rows·(SETTLE+1). That edge enters DONE, so done is high for exactly the one cycle following it.
- busy falls at the same edge where done rises.
- dut_out must be stable within SETTLE+1 cycles of the dut_in change. dut_out is a combinational path from dut_in; with SETTLE=0 it must settle within the same cycle.
- Minimum start-to-start spacing is rows·(SETTLE+1)+2 cycles.

## Test plan
- Reset: hold rst_n=0 for 2 edges with start=1 -> dut_in=0, busy=0, done=0, table_out=0, pass=0, mismatch_cnt=0, mismatch_idx=0.
- N_IN=2, SETTLE=1, DUT = ~(~x&y) & ~(~x&~y) (equals x), expected=4'b1100, start pulse at E0:
  - dut_in sequence is 0,0,1,1,2,2,3,3.
  - done is high only in the cycle after E0+8.
  - table_out=4'b1100, pass=1, mismatch_cnt=0.
- Same DUT with expected=4'b1110 -> table_out=4'b1100, pass=0, mismatch_cnt=1, mismatch_idx=1.
- Same DUT with expected=4'b0011 -> pass=0, mismatch_cnt=4, mismatch_idx=0.
- Same setup with start held high through the whole scan:
  - Mid-scan start has no effect and the row timing is unchanged.
  - Exactly one done pulse per scan.
  - A second scan begins on the IDLE cycle after DONE.
- rst_n=0 for one edge at E0+5 -> next cycle all outputs 0, state IDLE, no done pulse. A new start yields the full 4'b1100 result.
- SETTLE=3, N_IN=2, DUT = x XOR y, expected=4'b0110 -> done in the cycle after E0+16, pass=1.
